// File: rtl/fifo_pkg.sv
// Shared sizing defaults for the first-word-fall-through FIFO controller family.
// Capacity is 2**FIFO_DEPTH_LOG2 words. Both pointers wrap at this capacity.
package fifo_pkg;

    localparam int FIFO_WIDTH      = 40;
    localparam int FIFO_DEPTH_LOG2 = 10;
    localparam int FIFO_AFULL_TH   = 1000;
    localparam int FIFO_AEMPTY_TH  = 8;

    // Capacity in words, sized to the occupancy counter width (DEPTH_LOG2+1 bits).
    function automatic int unsigned fifo_capacity(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

endpackage

// File: rtl/fifo_fwft_ctrl_if.sv
// User write/pop bus, status flags and external single-port-read RAM hookup for fifo_fwft_ctrl.
// Master is the user/RAM side, slave is the controller.
interface fifo_fwft_ctrl_if #(
    parameter int WIDTH      = fifo_pkg::FIFO_WIDTH,
    parameter int DEPTH_LOG2 = fifo_pkg::FIFO_DEPTH_LOG2
);
    logic                  WE;
    logic [WIDTH-1:0]      DATA;
    logic                  RE;
    logic [WIDTH-1:0]      Q;
    logic                  FULL;
    logic                  AFULL;
    logic                  EMPTY;
    logic                  AEMPTY;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;
    logic [DEPTH_LOG2:0]   COUNT;
    logic [DEPTH_LOG2-1:0] MEM_WADDR;
    logic [WIDTH-1:0]      MEM_WDATA;
    logic                  MEM_WE;
    logic [DEPTH_LOG2-1:0] MEM_RADDR;
    logic                  MEM_RE;
    logic [WIDTH-1:0]      MEM_RDATA;

    modport master (
        output WE, DATA, RE, MEM_RDATA,
        input  Q, FULL, AFULL, EMPTY, AEMPTY, OVERFLOW, UNDERFLOW, COUNT,
        input  MEM_WADDR, MEM_WDATA, MEM_WE, MEM_RADDR, MEM_RE
    );

    modport slave (
        input  WE, DATA, RE, MEM_RDATA,
        output Q, FULL, AFULL, EMPTY, AEMPTY, OVERFLOW, UNDERFLOW, COUNT,
        output MEM_WADDR, MEM_WDATA, MEM_WE, MEM_RADDR, MEM_RE
    );

endinterface

// File: rtl/fifo_fwft_stage.sv
// Two-entry head/skid output stage fed by a 1-cycle-latency RAM read port.
// Head presents the FIFO front word. Skid absorbs a RAM word that arrives while head is held.
module fifo_fwft_stage #(
    parameter int WIDTH = fifo_pkg::FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pop,
    input  logic             issue,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] head,
    output logic             head_vld,
    output logic [1:0]       occ,
    output logic             inflight
);

    logic [WIDTH-1:0] skid;
    logic             skid_vld;

    assign occ = {1'b0, head_vld} + {1'b0, skid_vld};

    // The issue rule upstream caps occupancy plus in-flight reads at two,
    // so an arriving word never finds both entries held without a pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            head_vld <= 1'b0;
            skid     <= '0;
            skid_vld <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (pop) begin
                if (skid_vld) begin
                    head <= skid;
                    if (inflight) begin
                        skid <= rdata;
                    end else begin
                        skid_vld <= 1'b0;
                    end
                end else if (inflight) begin
                    head <= rdata;
                end else begin
                    head_vld <= 1'b0;
                end
            end else if (inflight) begin
                if (head_vld) begin
                    skid     <= rdata;
                    skid_vld <= 1'b1;
                end else begin
                    head     <= rdata;
                    head_vld <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_fwft_ctrl.sv
// FWFT FIFO controller over an external 1-cycle-read RAM. Write to Q valid takes 3 cycles from empty.
// Writes are dropped while FULL (OVERFLOW) and pops are ignored while EMPTY (UNDERFLOW). One write and one pop per cycle are sustained.
module fifo_fwft_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH      = FIFO_WIDTH,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int AFULL_TH   = FIFO_AFULL_TH,
    parameter int AEMPTY_TH  = FIFO_AEMPTY_TH
) (
    input  logic             CLK,
    input  logic             RESET_N,
    fifo_fwft_ctrl_if.slave  bus
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CAP        = CW'(fifo_capacity(DEPTH_LOG2));
    localparam logic [CW-1:0]         AFULL_LVL  = CW'(AFULL_TH);
    localparam logic [CW-1:0]         AEMPTY_LVL = CW'(AEMPTY_TH);

    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [CW-1:0]         ram_cnt;
    logic [CW-1:0]         ram_cnt_nxt;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic                  wr_acc;
    logic                  pop;
    logic                  issue;
    logic [2:0]            stage_load;

    logic [WIDTH-1:0]      head_dat;
    logic                  head_vld;
    logic [1:0]            occ;
    logic                  inflight;

    // ram_cnt only counts committed writes, so a read never targets the address written this cycle.
    always_comb begin
        wr_acc      = RESET_N && bus.WE && !full_q;
        pop         = RESET_N && bus.RE && head_vld;
        stage_load  = {1'b0, occ} + {2'b00, inflight};
        issue       = RESET_N && (ram_cnt != '0) &&
                      (stage_load < (pop ? 3'd3 : 3'd2));

        ram_cnt_nxt = ram_cnt;
        unique case ({wr_acc, issue})
            2'b10:   ram_cnt_nxt = ram_cnt + CNT_ONE;
            2'b01:   ram_cnt_nxt = ram_cnt - CNT_ONE;
            default: ram_cnt_nxt = ram_cnt;
        endcase

        count_nxt = count;
        unique case ({wr_acc, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (issue) begin
                rptr <= rptr + PTR_ONE;
            end
            ram_cnt  <= ram_cnt_nxt;
            count    <= count_nxt;
            full_q   <= (count_nxt == CAP);
            afull_q  <= (count_nxt >= AFULL_LVL);
            aempty_q <= (count_nxt <= AEMPTY_LVL);
            ovf_q    <= bus.WE && full_q;
            udf_q    <= bus.RE && !head_vld;
        end
    end

    fifo_fwft_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .pop      (pop),
        .issue    (issue),
        .rdata    (bus.MEM_RDATA),
        .head     (head_dat),
        .head_vld (head_vld),
        .occ      (occ),
        .inflight (inflight)
    );

    assign bus.MEM_WE    = wr_acc;
    assign bus.MEM_WADDR = wptr;
    assign bus.MEM_WDATA = bus.DATA;
    assign bus.MEM_RE    = issue;
    assign bus.MEM_RADDR = rptr;

    // EMPTY follows the head register, so Q is always valid whenever EMPTY is low.
    assign bus.Q         = head_dat;
    assign bus.EMPTY     = ~head_vld;
    assign bus.FULL      = full_q;
    assign bus.AFULL     = afull_q;
    assign bus.AEMPTY    = aempty_q;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.UNDERFLOW = udf_q;
    assign bus.COUNT     = count;

endmodule
